// File: rtl/lsu_rr_arbiter.sv
// Round-robin arbiter that funnels per-thread LSU read/write requests onto one
// memory-controller port, keeping a single request outstanding on each side.
module lsu_rr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_read_valid,
   input  logic [NUM_REQ-1:0]           req_write_valid,
   input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_write_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ*DATA_BITS-1:0] req_read_data,
   output logic                         mem_read_valid,
   output logic                         mem_write_valid,
   output logic [ADDR_BITS-1:0]         mem_addr,
   output logic [DATA_BITS-1:0]         mem_write_data,
   input  logic                         mem_read_ready,
   input  logic                         mem_write_ready,
   input  logic [DATA_BITS-1:0]         mem_read_data
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RELEASE
   } state_e;

   state_e                       state_q,   state_d;
   logic [PTR_W-1:0]             ptr_q,     ptr_d;
   logic [PTR_W-1:0]             g_q,       g_d;
   logic                         op_read_q, op_read_d;
   logic [ADDR_BITS-1:0]         addr_q,    addr_d;
   logic [DATA_BITS-1:0]         wdata_q,   wdata_d;
   logic                         mem_rv_q,  mem_rv_d;
   logic                         mem_wv_q,  mem_wv_d;
   logic [NUM_REQ-1:0]           ready_q,   ready_d;
   logic [NUM_REQ*DATA_BITS-1:0] rdata_q,   rdata_d;

   logic [NUM_REQ-1:0] cand;
   logic               cand_found;
   logic [PTR_W-1:0]   cand_idx;
   logic [PTR_W-1:0]   scan_idx;

   assign cand = req_read_valid | req_write_valid;

   // Circular scan starting at ptr; the first requester met wins.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      scan_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!cand_found && cand[scan_idx]) begin
            cand_found = 1'b1;
            cand_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts from its held value, so no path through the case can infer a latch.
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      op_read_d = op_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mem_rv_d  = mem_rv_q;
      mem_wv_d  = mem_wv_q;
      ready_d   = ready_q;
      rdata_d   = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cand_found) begin
               // A simultaneous read and write from one thread issues only the read.
               g_d       = cand_idx;
               op_read_d = req_read_valid[cand_idx];
               addr_d    = req_addr[int'(cand_idx)*ADDR_BITS +: ADDR_BITS];
               wdata_d   = req_write_data[int'(cand_idx)*DATA_BITS +: DATA_BITS];
               mem_rv_d  = req_read_valid[cand_idx];
               mem_wv_d  = ~req_read_valid[cand_idx];
               state_d   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (op_read_q && mem_read_ready) begin
               rdata_d[int'(g_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
               mem_rv_d     = 1'b0;
               ready_d[g_q] = 1'b1;
               state_d      = ST_RELEASE;
            end else if (!op_read_q && mem_write_ready) begin
               mem_wv_d     = 1'b0;
               ready_d[g_q] = 1'b1;
               state_d      = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (!req_read_valid[g_q] && !req_write_valid[g_q]) begin
               ready_d = '0;
               ptr_d   = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         g_q       <= '0;
         op_read_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_rv_q  <= 1'b0;
         mem_wv_q  <= 1'b0;
         ready_q   <= '0;
         // NOTE: the read-data bank is plain flops rather than a RAM, so it is cleared with everything else.
         rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking updates make every register sample pre-edge values.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         g_q       <= g_d;
         op_read_q <= op_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mem_rv_q  <= mem_rv_d;
         mem_wv_q  <= mem_wv_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
      end
   end

   assign req_ready       = ready_q;
   assign req_read_data   = rdata_q;
   assign mem_read_valid  = mem_rv_q;
   assign mem_write_valid = mem_wv_q;
   assign mem_addr        = addr_q;
   assign mem_write_data  = wdata_q;

endmodule

// File: tb/tb_lsu_rr_arbiter.sv
// Scoreboard bench for lsu_rr_arbiter: a round-robin reference model predicts the
// service order and data, a negedge monitor checks every completion and memory handshake.
`timescale 1ns/1ps
module tb_lsu_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_read_valid;
   logic [N-1:0]    req_write_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_write_data;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_read_data;
   logic            mem_read_valid;
   logic            mem_write_valid;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_write_data;
   logic            mem_read_ready;
   logic            mem_write_ready;
   logic [DW-1:0]   mem_read_data;

   always #5 clk = ~clk;

   lsu_rr_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_read_valid  (req_read_valid),
      .req_write_valid (req_write_valid),
      .req_addr        (req_addr),
      .req_write_data  (req_write_data),
      .req_ready       (req_ready),
      .req_read_data   (req_read_data),
      .mem_read_valid  (mem_read_valid),
      .mem_write_valid (mem_write_valid),
      .mem_addr        (mem_addr),
      .mem_write_data  (mem_write_data),
      .mem_read_ready  (mem_read_ready),
      .mem_write_ready (mem_write_ready),
      .mem_read_data   (mem_read_data)
   );

   typedef struct {
      int          thread;
      bit          is_read;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } exp_t;

   typedef struct {
      bit          rv;
      bit          wv;
      logic [7:0]  addr;
      logic [7:0]  wdata;
   } req_t;

   exp_t       exp_q[$];
   req_t       reqs[N][2];
   int         nreq[N];
   int         vectors = 0;
   int         miscompares = 0;

   logic [7:0] mem_image[256];
   logic [7:0] ref_mem[256];
   logic [7:0] last_rdata[N];
   int         model_ptr;

   bit         resp_en;
   bit         stray_en;
   int         wait_min, wait_max, wait_target, wait_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      model_ptr = 0;
      for (int i = 0; i < N; i++) last_rdata[i] = 8'h00;
   endtask

   task automatic push_exp(input int t, input req_t r);
      exp_t e;
      e.thread  = t;
      e.is_read = r.rv;
      e.addr    = r.addr;
      e.wdata   = r.wdata;
      if (r.rv) begin
         e.rdata       = ref_mem[r.addr];
         last_rdata[t] = e.rdata;
      end else begin
         ref_mem[r.addr] = r.wdata;
         e.rdata         = last_rdata[t];
      end
      exp_q.push_back(e);
      model_ptr = (t + 1) % N;
   endtask

   // All pending threads are served in circular order starting at the pointer.
   task automatic model_round();
      int start;
      start = model_ptr;
      for (int k = 0; k < N; k++) begin
         if (nreq[(start + k) % N] > 0) push_exp((start + k) % N, reqs[(start + k) % N][0]);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int i, input req_t r);
      req_read_valid[i]            = r.rv;
      req_write_valid[i]           = r.wv;
      req_addr[i*AW +: AW]         = r.addr;
      req_write_data[i*DW +: DW]   = r.wdata;
   endtask

   task automatic drop(input int i);
      req_read_valid[i]  = 1'b0;
      req_write_valid[i] = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) nreq[i] = 0;
   endtask

   task automatic set_resp(input int mn, input int mx, input bit st);
      wait_min    = mn;
      wait_max    = mx;
      stray_en    = st;
      wait_cnt    = 0;
      wait_target = mn;
   endtask

   function automatic req_t mk(input bit rv, input bit wv, input logic [7:0] a, input logic [7:0] d);
      req_t r;
      r.rv = rv; r.wv = wv; r.addr = a; r.wdata = d;
      return r;
   endfunction

   // Threads hold their request until req_ready, drop for one cycle, then issue the next one.
   task automatic run_round(input int budget);
      int idx[N];
      bit active[N];
      int cyc;
      bit busy;
      cyc = 0;
      for (int i = 0; i < N; i++) begin
         idx[i] = 0;
         active[i] = 1'b0;
         if (nreq[i] > 0) begin
            drive(i, reqs[i][0]);
            active[i] = 1'b1;
         end
      end
      busy = 1'b1;
      while (busy) begin
         @(posedge clk); #1;
         cyc++;
         busy = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (active[i] && req_ready[i]) begin
               drop(i);
               active[i] = 1'b0;
               idx[i]++;
            end else if (!active[i] && idx[i] < nreq[i]) begin
               drive(i, reqs[i][idx[i]]);
               active[i] = 1'b1;
            end
            if (active[i] || idx[i] < nreq[i]) busy = 1'b1;
         end
         if (busy && cyc > budget) begin
            check("round_timeout", 32'(cyc), 32'(budget));
            for (int i = 0; i < N; i++) drop(i);
            busy = 1'b0;
         end
      end
      @(posedge clk); #1;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // ---------------- memory responder ----------------
   initial begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = 8'h00;
      forever begin
         @(posedge clk); #1;
         mem_read_ready  = 1'b0;
         mem_write_ready = 1'b0;
         if (!resp_en) begin
            wait_cnt = 0;
         end else if (mem_read_valid || mem_write_valid) begin
            if (wait_cnt >= wait_target) begin
               if (mem_read_valid) begin
                  mem_read_ready = 1'b1;
                  mem_read_data  = mem_image[mem_addr];
               end else begin
                  mem_write_ready     = 1'b1;
                  mem_image[mem_addr] = mem_write_data;
               end
               wait_cnt    = 0;
               wait_target = int'($urandom_range(wait_max, wait_min));
            end else begin
               mem_read_data = 8'($urandom);
               if (stray_en && wait_cnt == 2) begin
                  if (mem_read_valid) mem_write_ready = 1'b1;
                  else                mem_read_ready  = 1'b1;
               end
               wait_cnt++;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [N-1:0] prev_ready, prev_rv, prev_wv, rise;
   logic         prev_mrv, prev_mwv, prev_acc, acc_now;
   logic [7:0]   prev_addr, prev_wdata;
   bit           acc_pending, acc_read;
   int           acc_age, rise_t;
   logic [7:0]   acc_addr, acc_wdata;
   exp_t         mon_e;

   initial begin
      prev_ready  = '0;
      prev_mrv    = 1'b0;
      prev_mwv    = 1'b0;
      prev_acc    = 1'b0;
      acc_pending = 1'b0;
      acc_age     = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_ready  = '0;
            prev_mrv    = 1'b0;
            prev_mwv    = 1'b0;
            prev_acc    = 1'b0;
            acc_pending = 1'b0;
         end else begin
            acc_now = (mem_read_valid && mem_read_ready) || (mem_write_valid && mem_write_ready);
            if (mem_read_valid || mem_write_valid)
               check("mem_valid_exclusive", 32'(mem_read_valid && mem_write_valid), 32'd0);
            if ((prev_mrv || prev_mwv) && !prev_acc) begin
               check("mem_valid_held", 32'({mem_read_valid, mem_write_valid}), 32'({prev_mrv, prev_mwv}));
               check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
               check("mem_wdata_stable", 32'(mem_write_data), 32'(prev_wdata));
            end
            if (prev_ready != '0) begin
               if (((prev_rv | prev_wv) & prev_ready) != '0)
                  check("ready_hold", 32'(req_ready), 32'(prev_ready));
               else
                  check("ready_release", 32'(req_ready), 32'd0);
            end
            if (acc_pending) acc_age++;
            rise = req_ready & ~prev_ready;
            if (rise != '0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ready", 32'(rise), 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  rise_t = 0;
                  for (int i = N - 1; i >= 0; i--) if (rise[i]) rise_t = i;
                  check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                  check("grant_thread", 32'(rise_t), 32'(mon_e.thread));
                  check("ready_latency", 32'(acc_pending && acc_age == 1), 32'd1);
                  check("mem_op_read", 32'(acc_read), 32'(mon_e.is_read));
                  check("mem_addr", 32'(acc_addr), 32'(mon_e.addr));
                  if (!mon_e.is_read) check("mem_wdata", 32'(acc_wdata), 32'(mon_e.wdata));
                  check("req_read_data", 32'(req_read_data[rise_t*DW +: DW]), 32'(mon_e.rdata));
               end
               acc_pending = 1'b0;
            end
            if (acc_now) begin
               acc_pending = 1'b1;
               acc_age     = 0;
               acc_read    = mem_read_valid;
               acc_addr    = mem_addr;
               acc_wdata   = mem_write_data;
            end
            prev_ready = req_ready;
            prev_rv    = req_read_valid;
            prev_wv    = req_write_valid;
            prev_mrv   = mem_read_valid;
            prev_mwv   = mem_write_valid;
            prev_addr  = mem_addr;
            prev_wdata = mem_write_data;
            prev_acc   = acc_now;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_req_read_data"}, req_read_data, 32'd0);
      check({tag, "_mem_read_valid"}, 32'(mem_read_valid), 32'd0);
      check({tag, "_mem_write_valid"}, 32'(mem_write_valid), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_write_data"}, 32'(mem_write_data), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      req_t r;
      int   w;
      reset           = 1'b1;
      req_read_valid  = '0;
      req_write_valid = '0;
      req_addr        = '0;
      req_write_data  = '0;
      for (int a = 0; a < 256; a++) begin
         mem_image[a] = 8'(a * 7 + 3);
         ref_mem[a]   = 8'(a * 7 + 3);
      end
      model_reset();
      set_resp(0, 3, 1'b1);
      resp_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("por");
      reset = 1'b0;
      @(posedge clk); #1;

      // Single read with zero-wait memory: valid at T+1, ready/data at T+2, held until drop.
      set_resp(0, 0, 1'b0);
      mem_image[8'h3C] = 8'hAA;
      ref_mem[8'h3C]   = 8'hAA;
      r = mk(1'b1, 1'b0, 8'h3C, 8'h00);
      push_exp(1, r);
      drive(1, r);
      @(posedge clk); #1;
      check("single_t1_read_valid", 32'(mem_read_valid), 32'd1);
      check("single_t1_write_valid", 32'(mem_write_valid), 32'd0);
      check("single_t1_addr", 32'(mem_addr), 32'h3C);
      @(posedge clk); #1;
      check("single_t2_ready", 32'(req_ready), 32'b0010);
      check("single_t2_data", 32'(req_read_data[1*DW +: DW]), 32'hAA);
      repeat (2) begin
         @(posedge clk); #1;
         check("single_ready_held", 32'(req_ready), 32'b0010);
      end
      drop(1);
      @(posedge clk); #1;
      check("single_ready_dropped", 32'(req_ready), 32'd0);
      set_resp(0, 3, 1'b1);

      // Reset in the middle of an ISSUE: everything clears and the pointer restarts at 0.
      resp_en = 1'b0;
      drive(2, mk(1'b1, 1'b0, 8'h9C, 8'h3E));
      w = 0;
      while (!mem_read_valid && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      check("rst_issue_reached", 32'(mem_read_valid), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_issue_rst");
      reset = 1'b0;
      model_reset();
      resp_en = 1'b1;
      clear_reqs();
      reqs[1][0] = mk(1'b1, 1'b0, 8'h21, 8'h00); nreq[1] = 1;
      reqs[2][0] = mk(1'b1, 1'b0, 8'h9C, 8'h3E); nreq[2] = 1;
      model_round();
      run_round(200);

      // Bring the pointer round to 0 (grant to thread 3 wraps it).
      clear_reqs();
      reqs[3][0] = mk(1'b1, 1'b0, 8'h55, 8'h00); nreq[3] = 1;
      model_round();
      run_round(200);

      // All four threads at once.
      clear_reqs();
      reqs[0][0] = mk(1'b1, 1'b0, 8'h40, 8'h00); nreq[0] = 1;
      reqs[1][0] = mk(1'b0, 1'b1, 8'h10, 8'h55); nreq[1] = 1;
      reqs[2][0] = mk(1'b1, 1'b0, 8'h10, 8'h00); nreq[2] = 1;
      reqs[3][0] = mk(1'b0, 1'b1, 8'h77, 8'hC3); nreq[3] = 1;
      model_round();
      run_round(400);

      // Fairness: thread 0 re-requests at once, thread 3 still gets in first.
      clear_reqs();
      reqs[0][0] = mk(1'b1, 1'b0, 8'h01, 8'h00);
      reqs[0][1] = mk(1'b0, 1'b1, 8'h02, 8'h99); nreq[0] = 2;
      reqs[3][0] = mk(1'b1, 1'b0, 8'h03, 8'h00); nreq[3] = 1;
      push_exp(0, reqs[0][0]);
      push_exp(3, reqs[3][0]);
      push_exp(0, reqs[0][1]);
      run_round(400);

      // Write backpressure for 5 cycles with a stray read_ready in the middle.
      set_resp(5, 5, 1'b1);
      clear_reqs();
      reqs[1][0] = mk(1'b0, 1'b1, 8'hA0, 8'h5A); nreq[1] = 1;
      model_round();
      run_round(200);
      set_resp(0, 3, 1'b1);

      // Read and write together on thread 2: only the read goes out; then a plain write.
      clear_reqs();
      reqs[2][0] = mk(1'b1, 1'b1, 8'h10, 8'hFF); nreq[2] = 1;
      model_round();
      run_round(200);
      clear_reqs();
      reqs[2][0] = mk(1'b0, 1'b1, 8'h10, 8'h66); nreq[2] = 1;
      model_round();
      run_round(200);

      // Randomized rounds over random subsets, ops, addresses and memory latency.
      for (int n = 0; n < 40; n++) begin
         int mask;
         int op;
         clear_reqs();
         mask = int'($urandom_range(15, 1));
         for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
               op = int'($urandom_range(3, 0));
               reqs[i][0] = mk(op != 1, op == 1 || op == 2, 8'($urandom_range(31, 0)), 8'($urandom));
               nreq[i] = 1;
            end
         end
         model_round();
         run_round(400);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
